pixel_write_buffer: RTL and testbench

Sink for the renderer's pixel stream. Accepts (x, y, color) writes over a valid/ready handshake and buffers them in a FIFO. Converts each pixel to a linear framebuffer address and writes it into the back half of a double-buffered 160x120 pixel memory. When the renderer signals frame completion, the block drains all pending writes and then swaps the front and back buffers for the VGA scan-out side.

---
 rtl/pixel_write_buffer.sv | 170 +++++++++++++++++
 tb/tb_pixel_write_buffer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer: renderer pixel sink. Accepted pixels are range-checked,
// turned into linear framebuffer addresses, queued, and written one per cycle
// into the back buffer. A frame_done request drains the queue and then swaps
// the front and back buffers.
module pixel_write_buffer #(
   parameter int WIDTH      = 160,
   parameter int HEIGHT     = 120,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 15
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_pix_valid,
   output logic              o_pix_ready,
   input  logic [8:0]        i_pix_x,
   input  logic [8:0]        i_pix_y,
   input  logic [8:0]        i_pix_color,
   input  logic              i_frame_done,
   input  logic              i_mem_wait,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [8:0]        o_mem_data,
   output logic              o_mem_sel,
   output logic              o_display_sel,
   output logic              o_swap_ack,
   output logic [7:0]        o_drop_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = ADDR_W + 9;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_FILL, S_DRAIN, S_SWAP, S_HOLD} state_t;

   state_t            r_state, w_next;

   // input stage: address is computed here, one cycle before the FIFO push
   logic              r_in_vld;
   logic [ADDR_W-1:0] r_in_addr;
   logic [8:0]        r_in_data;

   logic [EW-1:0]     r_fifo [FIFO_DEPTH];
   logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]     r_count;

   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [8:0]        r_mem_data;
   logic              r_display_sel;
   logic              r_swap_ack;
   logic [7:0]        r_drop_count;

   logic [CW-1:0]     w_occ;
   logic              w_full, w_accept, w_in_range, w_commit, w_pop, w_idle;
   logic [ADDR_W-1:0] w_x, w_y, w_addr;

   // The input stage slot is reserved against FIFO space, so the FIFO plus
   // the output register bound total capacity to FIFO_DEPTH + 1.
   assign w_occ      = r_count + CW'(r_in_vld);
   assign w_full     = (w_occ >= DEPTH_C);
   assign w_accept   = i_pix_valid && o_pix_ready;
   assign w_in_range = (i_pix_x < 9'(WIDTH)) && (i_pix_y < 9'(HEIGHT));
   assign w_commit   = r_mem_we && !i_mem_wait;
   assign w_pop      = (r_count != '0) && (!r_mem_we || w_commit);
   assign w_idle     = (r_count == '0) && !r_in_vld && (!r_mem_we || w_commit);
   assign w_x        = ADDR_W'(i_pix_x);
   assign w_y        = ADDR_W'(i_pix_y);
   assign w_addr     = (w_y << 7) + (w_y << 5) + w_x;

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_FILL;
      else         r_state <= w_next;
   end

   // FSM next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FILL:  if (i_frame_done) w_next = S_DRAIN;
         S_DRAIN: if (w_idle) w_next = S_SWAP;
         S_SWAP:  w_next = S_HOLD;
         S_HOLD:  if (!i_frame_done) w_next = S_FILL;
         default: w_next = S_FILL;
      endcase
   end

   // FSM outputs: only FILL accepts, never during the reset cycle
   always_comb begin
      o_pix_ready = !i_reset && (r_state == S_FILL) && !w_full;
   end

   // input stage: capture in-range pixels with their linear address
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_in_vld  <= 1'b0;
         r_in_addr <= '0;
         r_in_data <= '0;
      end else begin
         r_in_vld <= w_accept && w_in_range;
         if (w_accept && w_in_range) begin
            r_in_addr <= w_addr;
            r_in_data <= i_pix_color;
         end
      end
   end

   // FIFO storage (data needs no reset; pointers/count define validity)
   always_ff @(posedge i_clk) begin
      if (r_in_vld) r_fifo[r_wr_ptr] <= {r_in_addr, r_in_data};
   end

   // FIFO pointers and occupancy
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (r_in_vld) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)    r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({r_in_vld, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // output register: refill on empty or on commit, hold while stalled
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_mem_we   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_data <= '0;
      end else if (w_pop) begin
         r_mem_we                 <= 1'b1;
         {r_mem_addr, r_mem_data} <= r_fifo[r_rd_ptr];
      end else if (w_commit) begin
         r_mem_we <= 1'b0;
      end
   end

   // out-of-range drop counter, saturating
   always_ff @(posedge i_clk) begin
      if (i_reset)                                              r_drop_count <= '0;
      else if (w_accept && !w_in_range && r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
   end

   // buffer swap: toggle on the edge leaving SWAP, with a one-cycle ack
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_display_sel <= 1'b1;
         r_swap_ack    <= 1'b0;
      end else begin
         r_swap_ack <= (r_state == S_SWAP);
         if (r_state == S_SWAP) r_display_sel <= ~r_display_sel;
      end
   end

   assign o_mem_we      = r_mem_we;
   assign o_mem_addr    = r_mem_addr;
   assign o_mem_data    = r_mem_data;
   assign o_display_sel = r_display_sel;
   assign o_mem_sel     = ~r_display_sel;
   assign o_swap_ack    = r_swap_ack;
   assign o_drop_count  = r_drop_count;

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Directed bench for pixel_write_buffer: each task drives one scenario and
// checks its outputs against hand-computed values.
module tb_pixel_write_buffer;

   logic        clk = 1'b0;
   logic        reset, pix_valid, frame_done, mem_wait;
   logic [8:0]  pix_x, pix_y, pix_color;
   logic        pix_ready, mem_we, mem_sel, display_sel, swap_ack;
   logic [14:0] mem_addr;
   logic [8:0]  mem_data;
   logic [7:0]  drop_count;

   int total = 0;
   int bad   = 0;

   int cyc = 0;
   int we_cnt = 0;
   int swap_cnt = 0;
   int swap_cyc = 0;
   int wr_a[$];
   int wr_d[$];
   int wr_c[$];

   pixel_write_buffer dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_pix_valid  (pix_valid),
      .o_pix_ready  (pix_ready),
      .i_pix_x      (pix_x),
      .i_pix_y      (pix_y),
      .i_pix_color  (pix_color),
      .i_frame_done (frame_done),
      .i_mem_wait   (mem_wait),
      .o_mem_we     (mem_we),
      .o_mem_addr   (mem_addr),
      .o_mem_data   (mem_data),
      .o_mem_sel    (mem_sel),
      .o_display_sel(display_sel),
      .o_swap_ack   (swap_ack),
      .o_drop_count (drop_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // log committed writes and swap pulses, sampled mid-cycle
   always @(negedge clk) begin
      if (mem_we === 1'b1) we_cnt <= we_cnt + 1;
      if (mem_we === 1'b1 && mem_wait === 1'b0) begin
         wr_a.push_back(int'(mem_addr));
         wr_d.push_back(int'(mem_data));
         wr_c.push_back(cyc);
      end
      if (swap_ack === 1'b1) begin
         swap_cnt <= swap_cnt + 1;
         swap_cyc <= cyc;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; pix_valid = 1'b0; frame_done = 1'b0; mem_wait = 1'b0;
      pix_x = '0; pix_y = '0; pix_color = '0;
      tick; tick;
      total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", pix_ready); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", mem_we); end
      total++; if (mem_addr !== 15'd0 || mem_data !== 9'd0) begin bad++; $display("FAIL rst_addr_data: got %0d/%0d want 0/0", mem_addr, mem_data); end
      total++; if (display_sel !== 1'b1 || mem_sel !== 1'b0) begin bad++; $display("FAIL rst_sel: got disp=%b mem=%b want 1/0", display_sel, mem_sel); end
      total++; if (swap_ack !== 1'b0 || drop_count !== 8'd0) begin bad++; $display("FAIL rst_ack_drop: got %b/%0d want 0/0", swap_ack, drop_count); end
      reset = 1'b0;
      #1;
      total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after: got %b want 1", pix_ready); end
   endtask

   task automatic test_single;
      pix_valid = 1'b1; pix_x = 9'd3; pix_y = 9'd2; pix_color = 9'h1FF;
      tick;
      pix_valid = 1'b0;
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL single_t0: got we=%b want 0", mem_we); end
      tick;
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL single_t1: got we=%b want 0", mem_we); end
      tick;
      total++; if (mem_we !== 1'b1 || mem_addr !== 15'd323 || mem_data !== 9'h1FF || mem_sel !== 1'b0) begin
         bad++; $display("FAIL single_write: got we=%b addr=%0d data=%h sel=%b want 1/323/1ff/0", mem_we, mem_addr, mem_data, mem_sel);
      end
      tick;
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL single_once: got we=%b want 0", mem_we); end
   endtask

   task automatic test_bounds;
      int base, we0;
      base = wr_a.size(); we0 = we_cnt;
      pix_valid = 1'b1; pix_x = 9'd159; pix_y = 9'd119; pix_color = 9'h038;
      tick;
      pix_x = 9'd160; pix_y = 9'd0; pix_color = 9'h011;
      tick;
      pix_x = 9'd0; pix_y = 9'd120; pix_color = 9'h022;
      tick;
      pix_valid = 1'b0;
      repeat (5) tick;
      total++; if (wr_a.size() - base != 1 || we_cnt - we0 != 1) begin bad++; $display("FAIL bounds_nwrites: got %0d/%0d want 1/1", wr_a.size() - base, we_cnt - we0); end
      else begin
         total++; if (wr_a[base] != 19199 || wr_d[base] != 'h038) begin bad++; $display("FAIL bounds_write: got %0d/%h want 19199/038", wr_a[base], wr_d[base]); end
      end
      total++; if (drop_count !== 8'd2) begin bad++; $display("FAIL bounds_drop: got %0d want 2", drop_count); end
   endtask

   task automatic test_stall;
      int k, base;
      logic acc;
      k = 0;
      mem_wait = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (k < 12) begin
            pix_valid = 1'b1; pix_x = 9'(10 + k); pix_y = 9'd5; pix_color = 9'(256 + k);
         end else pix_valid = 1'b0;
         acc = pix_valid && pix_ready;
         tick;
         if (acc) k++;
      end
      pix_valid = 1'b0;
      total++; if (k != 9) begin bad++; $display("FAIL stall_accepted: got %0d want 9", k); end
      total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL stall_ready_low: got %b want 0", pix_ready); end
      total++; if (mem_we !== 1'b1 || mem_addr !== 15'd810) begin bad++; $display("FAIL stall_hold: got we=%b addr=%0d want 1/810", mem_we, mem_addr); end
      base = wr_a.size();
      mem_wait = 1'b0;
      tick;
      total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL stall_ready_back: got %b want 1", pix_ready); end
      repeat (12) tick;
      total++; if (wr_a.size() - base != 9) begin bad++; $display("FAIL stall_nwrites: got %0d want 9", wr_a.size() - base); end
      else begin
         for (int i = 0; i < 9; i++) begin
            total++;
            if (wr_a[base+i] != 810 + i || wr_d[base+i] != 256 + i || wr_c[base+i] != wr_c[base] + i) begin
               bad++; $display("FAIL stall_write%0d: got addr=%0d data=%0d cyc=%0d want %0d/%0d/%0d",
                               i, wr_a[base+i], wr_d[base+i], wr_c[base+i], 810 + i, 256 + i, wr_c[base] + i);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      int base, n0, rdy_bad;
      base = wr_a.size(); n0 = cyc; rdy_bad = 0;
      for (int i = 0; i < 6; i++) begin
         pix_valid = 1'b1; pix_x = 9'(20 + i); pix_y = 9'd3; pix_color = 9'(i + 1);
         if (pix_ready !== 1'b1) rdy_bad++;
         tick;
      end
      pix_valid = 1'b0;
      repeat (6) tick;
      total++; if (rdy_bad != 0) begin bad++; $display("FAIL b2b_ready: got %0d stalls want 0", rdy_bad); end
      total++; if (wr_a.size() - base != 6) begin bad++; $display("FAIL b2b_nwrites: got %0d want 6", wr_a.size() - base); end
      else begin
         total++; if (wr_c[base] != n0 + 3) begin bad++; $display("FAIL b2b_latency: got cyc %0d want %0d", wr_c[base], n0 + 3); end
         for (int i = 0; i < 6; i++) begin
            total++;
            if (wr_a[base+i] != 500 + i || wr_d[base+i] != i + 1 || wr_c[base+i] != n0 + 3 + i) begin
               bad++; $display("FAIL b2b_write%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                               i, wr_a[base+i], wr_d[base+i], wr_c[base+i], 500 + i, i + 1, n0 + 3 + i);
            end
         end
      end
   endtask

   task automatic test_swap;
      int base, sc;
      int exp_a[3] = '{16000, 16001, 16002};
      int exp_d[3] = '{'h0AA, 'h055, 'h1C7};
      mem_wait = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pix_valid = 1'b1; pix_x = 9'(i); pix_y = 9'd100; pix_color = 9'(exp_d[i]);
         tick;
      end
      pix_valid = 1'b0;
      frame_done = 1'b1;
      base = wr_a.size(); sc = swap_cnt;
      tick;
      total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL swap_ready_low: got %b want 0", pix_ready); end
      mem_wait = 1'b0;
      repeat (10) tick;
      total++; if (wr_a.size() - base != 3) begin bad++; $display("FAIL swap_nwrites: got %0d want 3", wr_a.size() - base); end
      else begin
         for (int i = 0; i < 3; i++) begin
            total++; if (wr_a[base+i] != exp_a[i] || wr_d[base+i] != exp_d[i]) begin
               bad++; $display("FAIL swap_write%0d: got %0d/%h want %0d/%h", i, wr_a[base+i], wr_d[base+i], exp_a[i], exp_d[i]);
            end
         end
         total++; if (swap_cyc != wr_c[base+2] + 2) begin bad++; $display("FAIL swap_timing: got cyc %0d want %0d", swap_cyc, wr_c[base+2] + 2); end
      end
      total++; if (swap_cnt - sc != 1) begin bad++; $display("FAIL swap_once: got %0d want 1", swap_cnt - sc); end
      total++; if (display_sel !== 1'b0 || mem_sel !== 1'b1) begin bad++; $display("FAIL swap_sel: got disp=%b mem=%b want 0/1", display_sel, mem_sel); end
      repeat (20) tick;
      total++; if (swap_cnt - sc != 1 || pix_ready !== 1'b0) begin bad++; $display("FAIL swap_hold: got swaps=%0d ready=%b want 1/0", swap_cnt - sc, pix_ready); end
      frame_done = 1'b0;
      tick;
      total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL swap_ready_back: got %b want 1", pix_ready); end
   endtask

   task automatic test_reset_drain;
      int we0;
      mem_wait = 1'b1;
      for (int i = 0; i < 5; i++) begin
         pix_valid = 1'b1; pix_x = 9'(40 + i); pix_y = 9'd7; pix_color = 9'(i);
         tick;
      end
      pix_valid = 1'b0;
      frame_done = 1'b1;
      tick;
      total++; if (pix_ready !== 1'b0 || mem_we !== 1'b1) begin bad++; $display("FAIL rdrain_pre: got ready=%b we=%b want 0/1", pix_ready, mem_we); end
      reset = 1'b1;
      tick;
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rdrain_we: got %b want 0", mem_we); end
      reset = 1'b0; frame_done = 1'b0; mem_wait = 1'b0;
      we0 = we_cnt;
      repeat (10) tick;
      total++; if (we_cnt != we0) begin bad++; $display("FAIL rdrain_nowrite: got %0d want 0", we_cnt - we0); end
      total++; if (display_sel !== 1'b1 || mem_sel !== 1'b0) begin bad++; $display("FAIL rdrain_sel: got %b/%b want 1/0", display_sel, mem_sel); end
      total++; if (drop_count !== 8'd0 || pix_ready !== 1'b1) begin bad++; $display("FAIL rdrain_drop_ready: got %0d/%b want 0/1", drop_count, pix_ready); end
   endtask

   task automatic test_zero_frame;
      frame_done = 1'b1;
      tick;
      total++; if (swap_ack !== 1'b0 || pix_ready !== 1'b0) begin bad++; $display("FAIL zero_drain: got ack=%b ready=%b want 0/0", swap_ack, pix_ready); end
      tick;
      total++; if (swap_ack !== 1'b0 || display_sel !== 1'b1) begin bad++; $display("FAIL zero_swapstate: got ack=%b disp=%b want 0/1", swap_ack, display_sel); end
      tick;
      total++; if (swap_ack !== 1'b1 || display_sel !== 1'b0) begin bad++; $display("FAIL zero_ack: got ack=%b disp=%b want 1/0", swap_ack, display_sel); end
      frame_done = 1'b0;
      tick;
      total++; if (swap_ack !== 1'b0 || pix_ready !== 1'b1) begin bad++; $display("FAIL zero_back: got ack=%b ready=%b want 0/1", swap_ack, pix_ready); end
   endtask

   task automatic test_saturation;
      int we0;
      we0 = we_cnt;
      pix_valid = 1'b1; pix_x = 9'd200; pix_y = 9'd0; pix_color = 9'h0F0;
      repeat (200) tick;
      total++; if (drop_count !== 8'd200) begin bad++; $display("FAIL sat_200: got %0d want 200", drop_count); end
      repeat (100) tick;
      pix_valid = 1'b0;
      total++; if (drop_count !== 8'd255) begin bad++; $display("FAIL sat_255: got %0d want 255", drop_count); end
      repeat (3) tick;
      total++; if (we_cnt != we0) begin bad++; $display("FAIL sat_nowrite: got %0d want 0", we_cnt - we0); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_bounds;
      test_stall;
      test_back_to_back;
      test_swap;
      test_reset_drain;
      test_zero_frame;
      test_saturation;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
